// File: rtl/aes_pkg.sv
// AES-128 shared definitions: sizes, state encoding, round constants and the
// GF(2^8) / byte-permutation helpers used by both the encrypt and decrypt datapaths.
package aes_pkg;

    localparam int BLK_W = 128;
    localparam int NR    = 10;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (0x9, 0xb, 0xd, 0xe for InvMixColumns).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    // Byte n of the block sits at index 15-n; state cell (row r, col c) is byte r+4c.
    function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
        logic [15:0][7:0] sb, o;
        sb = s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[15 - (r + 4*c)] = sb[15 - (r + 4*((c + 4 - r) % 4))];
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
        logic [15:0][7:0] sb, o;
        logic [7:0] a0, a1, a2, a3;
        sb = s;
        for (int c = 0; c < 4; c++) begin
            a0 = sb[15 - 4*c];
            a1 = sb[14 - 4*c];
            a2 = sb[13 - 4*c];
            a3 = sb[12 - 4*c];
            o[15 - 4*c] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
            o[14 - 4*c] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
            o[13 - 4*c] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
            o[12 - 4*c] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, one byte, purely combinational lookup.
module aes_inv_sbox (
    input  logic [7:0] sin,
    output logic [7:0] sout
);

    always_comb begin
        sout = 8'h00;
        case (sin)
            8'h00: sout = 8'h52; 8'h01: sout = 8'h09; 8'h02: sout = 8'h6a; 8'h03: sout = 8'hd5; 8'h04: sout = 8'h30; 8'h05: sout = 8'h36; 8'h06: sout = 8'ha5; 8'h07: sout = 8'h38;
            8'h08: sout = 8'hbf; 8'h09: sout = 8'h40; 8'h0a: sout = 8'ha3; 8'h0b: sout = 8'h9e; 8'h0c: sout = 8'h81; 8'h0d: sout = 8'hf3; 8'h0e: sout = 8'hd7; 8'h0f: sout = 8'hfb;
            8'h10: sout = 8'h7c; 8'h11: sout = 8'he3; 8'h12: sout = 8'h39; 8'h13: sout = 8'h82; 8'h14: sout = 8'h9b; 8'h15: sout = 8'h2f; 8'h16: sout = 8'hff; 8'h17: sout = 8'h87;
            8'h18: sout = 8'h34; 8'h19: sout = 8'h8e; 8'h1a: sout = 8'h43; 8'h1b: sout = 8'h44; 8'h1c: sout = 8'hc4; 8'h1d: sout = 8'hde; 8'h1e: sout = 8'he9; 8'h1f: sout = 8'hcb;
            8'h20: sout = 8'h54; 8'h21: sout = 8'h7b; 8'h22: sout = 8'h94; 8'h23: sout = 8'h32; 8'h24: sout = 8'ha6; 8'h25: sout = 8'hc2; 8'h26: sout = 8'h23; 8'h27: sout = 8'h3d;
            8'h28: sout = 8'hee; 8'h29: sout = 8'h4c; 8'h2a: sout = 8'h95; 8'h2b: sout = 8'h0b; 8'h2c: sout = 8'h42; 8'h2d: sout = 8'hfa; 8'h2e: sout = 8'hc3; 8'h2f: sout = 8'h4e;
            8'h30: sout = 8'h08; 8'h31: sout = 8'h2e; 8'h32: sout = 8'ha1; 8'h33: sout = 8'h66; 8'h34: sout = 8'h28; 8'h35: sout = 8'hd9; 8'h36: sout = 8'h24; 8'h37: sout = 8'hb2;
            8'h38: sout = 8'h76; 8'h39: sout = 8'h5b; 8'h3a: sout = 8'ha2; 8'h3b: sout = 8'h49; 8'h3c: sout = 8'h6d; 8'h3d: sout = 8'h8b; 8'h3e: sout = 8'hd1; 8'h3f: sout = 8'h25;
            8'h40: sout = 8'h72; 8'h41: sout = 8'hf8; 8'h42: sout = 8'hf6; 8'h43: sout = 8'h64; 8'h44: sout = 8'h86; 8'h45: sout = 8'h68; 8'h46: sout = 8'h98; 8'h47: sout = 8'h16;
            8'h48: sout = 8'hd4; 8'h49: sout = 8'ha4; 8'h4a: sout = 8'h5c; 8'h4b: sout = 8'hcc; 8'h4c: sout = 8'h5d; 8'h4d: sout = 8'h65; 8'h4e: sout = 8'hb6; 8'h4f: sout = 8'h92;
            8'h50: sout = 8'h6c; 8'h51: sout = 8'h70; 8'h52: sout = 8'h48; 8'h53: sout = 8'h50; 8'h54: sout = 8'hfd; 8'h55: sout = 8'hed; 8'h56: sout = 8'hb9; 8'h57: sout = 8'hda;
            8'h58: sout = 8'h5e; 8'h59: sout = 8'h15; 8'h5a: sout = 8'h46; 8'h5b: sout = 8'h57; 8'h5c: sout = 8'ha7; 8'h5d: sout = 8'h8d; 8'h5e: sout = 8'h9d; 8'h5f: sout = 8'h84;
            8'h60: sout = 8'h90; 8'h61: sout = 8'hd8; 8'h62: sout = 8'hab; 8'h63: sout = 8'h00; 8'h64: sout = 8'h8c; 8'h65: sout = 8'hbc; 8'h66: sout = 8'hd3; 8'h67: sout = 8'h0a;
            8'h68: sout = 8'hf7; 8'h69: sout = 8'he4; 8'h6a: sout = 8'h58; 8'h6b: sout = 8'h05; 8'h6c: sout = 8'hb8; 8'h6d: sout = 8'hb3; 8'h6e: sout = 8'h45; 8'h6f: sout = 8'h06;
            8'h70: sout = 8'hd0; 8'h71: sout = 8'h2c; 8'h72: sout = 8'h1e; 8'h73: sout = 8'h8f; 8'h74: sout = 8'hca; 8'h75: sout = 8'h3f; 8'h76: sout = 8'h0f; 8'h77: sout = 8'h02;
            8'h78: sout = 8'hc1; 8'h79: sout = 8'haf; 8'h7a: sout = 8'hbd; 8'h7b: sout = 8'h03; 8'h7c: sout = 8'h01; 8'h7d: sout = 8'h13; 8'h7e: sout = 8'h8a; 8'h7f: sout = 8'h6b;
            8'h80: sout = 8'h3a; 8'h81: sout = 8'h91; 8'h82: sout = 8'h11; 8'h83: sout = 8'h41; 8'h84: sout = 8'h4f; 8'h85: sout = 8'h67; 8'h86: sout = 8'hdc; 8'h87: sout = 8'hea;
            8'h88: sout = 8'h97; 8'h89: sout = 8'hf2; 8'h8a: sout = 8'hcf; 8'h8b: sout = 8'hce; 8'h8c: sout = 8'hf0; 8'h8d: sout = 8'hb4; 8'h8e: sout = 8'he6; 8'h8f: sout = 8'h73;
            8'h90: sout = 8'h96; 8'h91: sout = 8'hac; 8'h92: sout = 8'h74; 8'h93: sout = 8'h22; 8'h94: sout = 8'he7; 8'h95: sout = 8'had; 8'h96: sout = 8'h35; 8'h97: sout = 8'h85;
            8'h98: sout = 8'he2; 8'h99: sout = 8'hf9; 8'h9a: sout = 8'h37; 8'h9b: sout = 8'he8; 8'h9c: sout = 8'h1c; 8'h9d: sout = 8'h75; 8'h9e: sout = 8'hdf; 8'h9f: sout = 8'h6e;
            8'ha0: sout = 8'h47; 8'ha1: sout = 8'hf1; 8'ha2: sout = 8'h1a; 8'ha3: sout = 8'h71; 8'ha4: sout = 8'h1d; 8'ha5: sout = 8'h29; 8'ha6: sout = 8'hc5; 8'ha7: sout = 8'h89;
            8'ha8: sout = 8'h6f; 8'ha9: sout = 8'hb7; 8'haa: sout = 8'h62; 8'hab: sout = 8'h0e; 8'hac: sout = 8'haa; 8'had: sout = 8'h18; 8'hae: sout = 8'hbe; 8'haf: sout = 8'h1b;
            8'hb0: sout = 8'hfc; 8'hb1: sout = 8'h56; 8'hb2: sout = 8'h3e; 8'hb3: sout = 8'h4b; 8'hb4: sout = 8'hc6; 8'hb5: sout = 8'hd2; 8'hb6: sout = 8'h79; 8'hb7: sout = 8'h20;
            8'hb8: sout = 8'h9a; 8'hb9: sout = 8'hdb; 8'hba: sout = 8'hc0; 8'hbb: sout = 8'hfe; 8'hbc: sout = 8'h78; 8'hbd: sout = 8'hcd; 8'hbe: sout = 8'h5a; 8'hbf: sout = 8'hf4;
            8'hc0: sout = 8'h1f; 8'hc1: sout = 8'hdd; 8'hc2: sout = 8'ha8; 8'hc3: sout = 8'h33; 8'hc4: sout = 8'h88; 8'hc5: sout = 8'h07; 8'hc6: sout = 8'hc7; 8'hc7: sout = 8'h31;
            8'hc8: sout = 8'hb1; 8'hc9: sout = 8'h12; 8'hca: sout = 8'h10; 8'hcb: sout = 8'h59; 8'hcc: sout = 8'h27; 8'hcd: sout = 8'h80; 8'hce: sout = 8'hec; 8'hcf: sout = 8'h5f;
            8'hd0: sout = 8'h60; 8'hd1: sout = 8'h51; 8'hd2: sout = 8'h7f; 8'hd3: sout = 8'ha9; 8'hd4: sout = 8'h19; 8'hd5: sout = 8'hb5; 8'hd6: sout = 8'h4a; 8'hd7: sout = 8'h0d;
            8'hd8: sout = 8'h2d; 8'hd9: sout = 8'he5; 8'hda: sout = 8'h7a; 8'hdb: sout = 8'h9f; 8'hdc: sout = 8'h93; 8'hdd: sout = 8'hc9; 8'hde: sout = 8'h9c; 8'hdf: sout = 8'hef;
            8'he0: sout = 8'ha0; 8'he1: sout = 8'he0; 8'he2: sout = 8'h3b; 8'he3: sout = 8'h4d; 8'he4: sout = 8'hae; 8'he5: sout = 8'h2a; 8'he6: sout = 8'hf5; 8'he7: sout = 8'hb0;
            8'he8: sout = 8'hc8; 8'he9: sout = 8'heb; 8'hea: sout = 8'hbb; 8'heb: sout = 8'h3c; 8'hec: sout = 8'h83; 8'hed: sout = 8'h53; 8'hee: sout = 8'h99; 8'hef: sout = 8'h61;
            8'hf0: sout = 8'h17; 8'hf1: sout = 8'h2b; 8'hf2: sout = 8'h04; 8'hf3: sout = 8'h7e; 8'hf4: sout = 8'hba; 8'hf5: sout = 8'h77; 8'hf6: sout = 8'hd6; 8'hf7: sout = 8'h26;
            8'hf8: sout = 8'he1; 8'hf9: sout = 8'h69; 8'hfa: sout = 8'h14; 8'hfb: sout = 8'h63; 8'hfc: sout = 8'h55; 8'hfd: sout = 8'h21; 8'hfe: sout = 8'h0c; 8'hff: sout = 8'h7d;
        endcase
    end

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, starting from the
// round-10 key and walking the key schedule backwards on the fly.
module aes128_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] din,
    input  logic [BLK_W-1:0] kin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] dout,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [BLK_W-1:0] st, key, kp, isr, isb, t;
    logic [3:0]       rnd;
    logic [31:0]      w0, w1, w2, w3, w0n, w1n, w2n, w3n, subw;
    logic             accept, rnd_ok;

    assign accept = (state == IDLE) && in_valid;
    assign rnd_ok = (rnd != 4'd0) && (rnd <= 4'(NR));

    // Undo one key-expansion step: recover the previous round key from the current one.
    assign {w0, w1, w2, w3} = key;
    assign w3n  = w3 ^ w2;
    assign w2n  = w2 ^ w1;
    assign w1n  = w1 ^ w0;
    assign subw = {sbox(w3n[23:16]), sbox(w3n[15:8]), sbox(w3n[7:0]), sbox(w3n[31:24])};
    assign w0n  = w0 ^ subw ^ {rcon(rnd), 24'h0};
    assign kp   = {w0n, w1n, w2n, w3n};

    assign isr = inv_shift_rows(st);

    for (genvar i = 0; i < 16; i++) begin : g_isub
        aes_inv_sbox u_isbox (
            .sin  (isr[8*i +: 8]),
            .sout (isb[8*i +: 8])
        );
    end

    assign t    = isb ^ kp;
    assign dout = st;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // An out-of-range round counter aborts the block rather than emitting garbage.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (!rnd_ok)            state_nxt = IDLE;
                else if (rnd == 4'd1)   state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st  <= '0;
            key <= '0;
            rnd <= '0;
        end else if (accept) begin
            st  <= din ^ kin;
            key <= kin;
            rnd <= 4'(NR);
        end else if (state == ROUND && rnd_ok) begin
            st  <= (rnd != 4'd1) ? inv_mix_columns(t) : t;
            key <= kp;
            rnd <= rnd - 4'd1;
        end
    end

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Self-checking bench for the iterative AES-128 decryptor: FIPS vectors, latency,
// backpressure, mid-operation reset, back-to-back blocks and an encrypt/decrypt round trip.
module tb_aes128_inv_cipher_iter;
    import aes_pkg::*;

    logic         clock = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] din, kin, dout;
    logic [127:0] expQ[$];
    int           nChecks = 0;
    int           nFails  = 0;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes128_inv_cipher_iter dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .kin       (kin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Encrypt-side reference used to build round-trip vectors.
    function automatic logic [7:0] tbXtime(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [127:0] tbSubBytes(input logic [127:0] s);
        logic [15:0][7:0] sb, o;
        sb = s;
        for (int i = 0; i < 16; i++) o[i] = sbox(sb[i]);
        return o;
    endfunction

    function automatic logic [127:0] tbShiftRows(input logic [127:0] s);
        logic [15:0][7:0] sb, o;
        sb = s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[15 - (r + 4*c)] = sb[15 - (r + 4*((c + r) % 4))];
        return o;
    endfunction

    function automatic logic [127:0] tbMixColumns(input logic [127:0] s);
        logic [15:0][7:0] sb, o;
        logic [7:0] a0, a1, a2, a3;
        sb = s;
        for (int c = 0; c < 4; c++) begin
            a0 = sb[15 - 4*c]; a1 = sb[14 - 4*c]; a2 = sb[13 - 4*c]; a3 = sb[12 - 4*c];
            o[15 - 4*c] = tbXtime(a0) ^ tbXtime(a1) ^ a1 ^ a2 ^ a3;
            o[14 - 4*c] = a0 ^ tbXtime(a1) ^ tbXtime(a2) ^ a2 ^ a3;
            o[13 - 4*c] = a0 ^ a1 ^ tbXtime(a2) ^ tbXtime(a3) ^ a3;
            o[12 - 4*c] = tbXtime(a0) ^ a0 ^ a1 ^ a2 ^ tbXtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] tbNextKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, tw;
        {w0, w1, w2, w3} = k;
        tw = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ tw;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic encrypt(input logic [127:0] pt, input logic [127:0] k0,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [127:0] s, k;
        logic [7:0]   rc;
        s = pt ^ k0;
        k = k0;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            s = tbShiftRows(tbSubBytes(s));
            if (r != 10) s = tbMixColumns(s);
            k = tbNextKey(k, rc);
            s = s ^ k;
            rc = tbXtime(rc);
        end
        ct = s;
        k10 = k;
    endtask

    task automatic checkEq(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        nChecks++;
        assert (obs === expv) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one block, push its plaintext, and return on the negedge after the accept edge.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt);
        int n;
        @(negedge clock);
        din = ct;
        kin = k;
        in_valid = 1'b1;
        expQ.push_back(pt);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        checkEq("accept_wait", 128'(n < 40), 128'(1));
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid counting edges, then compare against the scoreboard head.
    task automatic checkOutput(input string tag, input int expLat);
        logic [127:0] e;
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        checkEq({tag, "_valid"}, 128'(out_valid), 128'(1));
        if (expLat >= 0) checkEq({tag, "_latency"}, 128'(n), 128'(expLat));
        checkEq({tag, "_ctrl"}, 128'({in_ready, busy}), 128'(2'b01));
        e = (expQ.size() > 0) ? expQ.pop_front() : 'x;
        checkEq({tag, "_dout"}, dout, e);
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checkEq({tag, "_handoff"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
    endtask

    initial begin
        logic [127:0] hold, rk, rp, rc, rk10;
        int           seen;

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        din = '0;
        kin = '0;
        repeat (2) @(negedge clock);
        checkEq("reset_ctrl", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        checkEq("reset_dout", dout, '0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] FIPS-197 C.1 with latency check");
        applyStimulus(C1_CT, C1_KEY, C1_PT);
        checkOutput("c1", 10);
        handoff("c1");

        $display("[TB] FIPS-197 B with 20 cycles of backpressure");
        applyStimulus(B_CT, B_KEY, B_PT);
        checkOutput("fipsb", 10);
        hold = dout;
        din = C1_CT;
        kin = C1_KEY;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkEq("bp_dout", dout, hold);
            checkEq("bp_ctrl", 128'({out_valid, in_ready, busy}), 128'(3'b101));
        end
        out_ready = 1'b1;
        expQ.push_back(C1_PT);
        @(negedge clock);
        out_ready = 1'b0;
        checkEq("bp_release", 128'({out_valid, in_ready, busy}), 128'(3'b010));
        @(negedge clock);
        checkEq("bp_accept", 128'({in_ready, busy}), 128'(2'b01));
        in_valid = 1'b0;
        checkOutput("bp_second", 10);
        handoff("bp_second");

        $display("[TB] reset in the middle of a block");
        @(negedge clock);
        din = C1_CT;
        kin = C1_KEY;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        checkEq("pre_reset_busy", 128'(busy), 128'(1));
        reset = 1'b1;
        #1;
        checkEq("mid_reset_ctrl", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        checkEq("mid_reset_dout", dout, '0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        checkEq("no_out_after_reset", 128'(seen), 128'(0));
        applyStimulus(C1_CT, C1_KEY, C1_PT);
        checkOutput("post_reset", 10);
        handoff("post_reset");

        $display("[TB] back-to-back with in_valid held");
        @(negedge clock);
        din = C1_CT;
        kin = C1_KEY;
        in_valid = 1'b1;
        out_ready = 1'b1;
        expQ.push_back(C1_PT);
        @(negedge clock);
        din = B_CT;
        kin = B_KEY;
        expQ.push_back(B_PT);
        checkOutput("b2b_first", 10);
        @(negedge clock);
        checkEq("b2b_gap", 128'({out_valid, in_ready, busy}), 128'(3'b010));
        @(negedge clock);
        checkEq("b2b_accept", 128'({in_ready, busy}), 128'(2'b01));
        in_valid = 1'b0;
        checkOutput("b2b_second", 10);
        @(negedge clock);
        out_ready = 1'b0;
        checkEq("b2b_done", 128'({out_valid, in_ready}), 128'(2'b01));

        $display("[TB] round trip against the encrypt reference");
        for (int i = 0; i < 100; i++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            encrypt(rp, rk, rc, rk10);
            applyStimulus(rc, rk10, rp);
            checkOutput("roundtrip", 10);
            handoff("roundtrip");
        end

        checkEq("scoreboard_empty", 128'(expQ.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
